// File: rtl/ds_pkg.sv
// Shared constants for the DS-SE link receiver: control codes, NULL hunt
// pattern, receiver state encoding and payload lengths.
package ds_pkg;

  typedef enum logic [2:0] {HUNT, HDR_P, HDR_C, DATA, CTRL} rx_state_t;

  // Control codes as {first received, second received}
  localparam logic [1:0] CODE_FCT  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b01;
  localparam logic [1:0] CODE_EOP2 = 2'b10;
  localparam logic [1:0] CODE_ESC  = 2'b11;

  // Hunt window holds the oldest bit in [0]; bit 0 (ESC parity) is don't-care
  localparam logic [7:0] NULL_PAT  = 8'b0010_1110;
  localparam logic [7:0] NULL_MASK = 8'b1111_1110;

  localparam logic [3:0] DATA_LEN = 4'd8;
  localparam logic [3:0] CTRL_LEN = 4'd2;

  localparam logic [7:0] EOP1_BYTE = 8'h00;
  localparam logic [7:0] EOP2_BYTE = 8'h01;

  function automatic logic parity_ok(input logic acc, input logic p, input logic c);
    return acc ^ p ^ c;
  endfunction

endpackage

// File: rtl/ds_bit_recover.sv
// Synchronises the D/S pair, flags each recovered bit on a D xor S change and
// times out the link when transitions stop while it is up.
module ds_bit_recover #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_LIMIT  = 64,
  parameter int DISC_W      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic s_in,
  input  logic link_up,
  output logic bit_valid,
  output logic bit_val,
  output logic disc_timeout
);

  localparam logic [DISC_W-1:0] DISC_MAX  = DISC_W'(DISC_LIMIT);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISC_LIMIT - 1);

  logic [SYNC_STAGES-1:0] d_sync;
  logic [SYNC_STAGES-1:0] s_sync;
  logic                   ds_prev;
  logic [DISC_W-1:0]      disc_cnt;
  logic                   d_s;
  logic                   s_s;

  assign d_s          = d_sync[SYNC_STAGES-1];
  assign s_s          = s_sync[SYNC_STAGES-1];
  assign bit_valid    = (d_s ^ s_s) != ds_prev;
  assign bit_val      = d_s;
  assign disc_timeout = link_up && !bit_valid && (disc_cnt == DISC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sync   <= '0;
      s_sync   <= '0;
      ds_prev  <= 1'b0;
      disc_cnt <= '0;
    end else begin
      d_sync  <= {d_sync[SYNC_STAGES-2:0], d_in};
      s_sync  <= {s_sync[SYNC_STAGES-2:0], s_in};
      ds_prev <= d_s ^ s_s;
      if (!link_up || bit_valid)
        disc_cnt <= '0;
      else if (disc_cnt != DISC_MAX)
        disc_cnt <= disc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ds_link_rx.sv
// DS-SE link receiver: hunts for the first NULL, then decodes characters,
// checks parity/escape sequences and holds one character for the consumer.
module ds_link_rx
  import ds_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_LIMIT  = 64,
  parameter int DISC_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_in,
  input  logic       s_in,
  output logic [7:0] rx_data,
  output logic       rx_ctrl,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       fct_rcvd,
  output logic       null_rcvd,
  output logic       link_up,
  output logic       err_parity,
  output logic       err_esc,
  output logic       err_disc,
  output logic       err_ovr
);

  rx_state_t   state;
  logic [7:0]  sr;
  logic [3:0]  cnt;
  logic        par_acc;
  logic        p_bit;
  logic        esc_pend;
  logic        bit_valid;
  logic        bit_val;
  logic        disc_timeout;

  logic [7:0]  sr_next;
  logic [1:0]  code;
  logic        last_bit;
  logic        hunt_hit;
  logic        present;
  logic [7:0]  pres_data;
  logic        can_load;

  ds_bit_recover #(
    .SYNC_STAGES(SYNC_STAGES),
    .DISC_LIMIT (DISC_LIMIT),
    .DISC_W     (DISC_W)
  ) u_bit_recover (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .s_in        (s_in),
    .link_up     (link_up),
    .bit_valid   (bit_valid),
    .bit_val     (bit_val),
    .disc_timeout(disc_timeout)
  );

  // Payload shifts in at the MSB, so a finished data byte is LSB-first aligned
  always_comb begin
    sr_next   = {bit_val, sr[7:1]};
    code      = {sr_next[6], sr_next[7]};
    hunt_hit  = (sr_next & NULL_MASK) == NULL_PAT;
    last_bit  = bit_valid && !disc_timeout && (state == DATA || state == CTRL) && cnt == 4'd1;
    present   = last_bit && !esc_pend &&
                (state == DATA || code == CODE_EOP1 || code == CODE_EOP2);
    pres_data = (state == DATA) ? sr_next : ((code == CODE_EOP1) ? EOP1_BYTE : EOP2_BYTE);
    can_load  = !rx_valid || rx_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      sr         <= '0;
      cnt        <= '0;
      par_acc    <= 1'b0;
      p_bit      <= 1'b0;
      esc_pend   <= 1'b0;
      rx_data    <= '0;
      rx_ctrl    <= 1'b0;
      rx_valid   <= 1'b0;
      fct_rcvd   <= 1'b0;
      null_rcvd  <= 1'b0;
      link_up    <= 1'b0;
      err_parity <= 1'b0;
      err_esc    <= 1'b0;
      err_disc   <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      fct_rcvd   <= 1'b0;
      null_rcvd  <= 1'b0;
      err_parity <= 1'b0;
      err_esc    <= 1'b0;
      err_disc   <= 1'b0;
      err_ovr    <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (disc_timeout) begin
        err_disc <= 1'b1;
        link_up  <= 1'b0;
        esc_pend <= 1'b0;
        sr       <= '0;
        state    <= HUNT;
      end else if (bit_valid) begin
        unique case (state)
          HUNT: begin
            if (hunt_hit) begin
              null_rcvd <= 1'b1;
              link_up   <= 1'b1;
              par_acc   <= 1'b0;
              esc_pend  <= 1'b0;
              sr        <= '0;
              state     <= HDR_P;
            end else begin
              sr <= sr_next;
            end
          end
          HDR_P: begin
            p_bit <= bit_val;
            state <= HDR_C;
          end
          HDR_C: begin
            if (!parity_ok(par_acc, p_bit, bit_val)) begin
              err_parity <= 1'b1;
              link_up    <= 1'b0;
              esc_pend   <= 1'b0;
              sr         <= '0;
              state      <= HUNT;
            end else begin
              par_acc <= 1'b0;
              cnt     <= bit_val ? CTRL_LEN : DATA_LEN;
              state   <= bit_val ? CTRL : DATA;
            end
          end
          DATA, CTRL: begin
            sr      <= sr_next;
            par_acc <= par_acc ^ bit_val;
            cnt     <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= HDR_P;
              if (esc_pend) begin
                esc_pend <= 1'b0;
                if (state == CTRL && code == CODE_FCT) begin
                  null_rcvd <= 1'b1;
                end else begin
                  err_esc <= 1'b1;
                  link_up <= 1'b0;
                  sr      <= '0;
                  state   <= HUNT;
                end
              end else if (state == CTRL && code == CODE_FCT) begin
                fct_rcvd <= 1'b1;
              end else if (state == CTRL && code == CODE_ESC) begin
                esc_pend <= 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end

      // A busy output register keeps its character and flags the lost one
      if (present) begin
        if (can_load) begin
          rx_valid <= 1'b1;
          rx_data  <= pres_data;
          rx_ctrl  <= (state == CTRL);
        end else begin
          err_ovr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ds_link_rx.sv
// Directed bench for ds_link_rx: a DS transmitter model drives characters,
// expected characters are queued and compared on each consumer handshake.
module tb_ds_link_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_in;
  logic       s_in;
  logic [7:0] rx_data;
  logic       rx_ctrl;
  logic       rx_valid;
  logic       rx_ready;
  logic       fct_rcvd;
  logic       null_rcvd;
  logic       link_up;
  logic       err_parity;
  logic       err_esc;
  logic       err_disc;
  logic       err_ovr;

  int vectors = 0;
  int miscompares = 0;
  int null_cnt, fct_cnt, par_cnt, esc_cnt, disc_cnt, ovr_cnt, char_cnt;
  logic prev_par;
  logic [8:0] exp_q[$];

  ds_link_rx #(.SYNC_STAGES(2), .DISC_LIMIT(64), .DISC_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .s_in      (s_in),
    .rx_data   (rx_data),
    .rx_ctrl   (rx_ctrl),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .fct_rcvd  (fct_rcvd),
    .null_rcvd (null_rcvd),
    .link_up   (link_up),
    .err_parity(err_parity),
    .err_esc   (err_esc),
    .err_disc  (err_disc),
    .err_ovr   (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    null_cnt = 0; fct_cnt = 0; par_cnt = 0; esc_cnt = 0;
    disc_cnt = 0; ovr_cnt = 0; char_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // DS coding: D carries the bit, S toggles whenever D does not
  task automatic send_bit(input logic b);
    if (b !== d_in) d_in = b;
    else s_in = ~s_in;
    wait_cycles(4);
  endtask

  task automatic send_char(input logic ctrl, input logic [7:0] pay, input logic flip_p);
    logic p;
    p = 1'b1 ^ prev_par ^ ctrl ^ flip_p;
    send_bit(p);
    send_bit(ctrl);
    if (ctrl) begin
      send_bit(pay[1]);
      send_bit(pay[0]);
      prev_par = pay[1] ^ pay[0];
    end else begin
      for (int i = 0; i < 8; i++) send_bit(pay[i]);
      prev_par = ^pay;
    end
  endtask

  task automatic send_null();
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b1, 8'h00, 1'b0);
  endtask

  // Monitor: pulse counters and scoreboard pop on each handshake
  always @(negedge clk) begin
    if (!rst) begin
      null_cnt += int'(null_rcvd);
      fct_cnt  += int'(fct_rcvd);
      par_cnt  += int'(err_parity);
      esc_cnt  += int'(err_esc);
      disc_cnt += int'(err_disc);
      ovr_cnt  += int'(err_ovr);
      if (rx_valid && rx_ready) begin
        char_cnt++;
        check("char_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("char_value", {23'd0, rx_ctrl, rx_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; d_in = 1'b0; s_in = 1'b0; rx_ready = 1'b1; prev_par = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {rx_data, rx_ctrl, rx_valid, fct_rcvd, null_rcvd, link_up,
                            err_parity, err_esc, err_disc, err_ovr}, 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    // Link bring-up with two NULLs
    send_null();
    send_null();
    wait_cycles(6);
    check("nulls_seen", null_cnt, 2);
    check("link_up_after_null", link_up, 1);
    check("no_errors_bringup", par_cnt + esc_cnt + disc_cnt + ovr_cnt, 0);
    check("rx_valid_idle", rx_valid, 0);

    // Data then EOP_1
    clear_counts();
    send_null();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, 8'h00});
    send_char(1'b0, 8'hA5, 1'b0);
    send_char(1'b1, 8'h01, 1'b0);
    wait_cycles(6);
    check("chars_delivered", char_cnt, 2);
    check("queue_drained_1", exp_q.size(), 0);
    check("null_with_data", null_cnt, 1);

    // Parity error on an FCT, then recovery
    clear_counts();
    send_null();
    send_char(1'b1, 8'h00, 1'b1);
    wait_cycles(2);
    check("parity_err", par_cnt, 1);
    check("link_down_parity", link_up, 0);
    check("no_fct_on_bad_parity", fct_cnt, 0);
    send_null();
    wait_cycles(6);
    check("link_restored", link_up, 1);

    // ESC followed by EOP_2
    clear_counts();
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b1, 8'h02, 1'b0);
    wait_cycles(6);
    check("esc_err", esc_cnt, 1);
    check("link_down_esc", link_up, 0);
    check("no_char_on_esc_err", char_cnt + int'(rx_valid), 0);
    send_null();
    clear_counts();
    send_char(1'b1, 8'h00, 1'b0);
    wait_cycles(6);
    check("fct_pulse", fct_cnt, 1);
    check("fct_not_null", null_cnt, 0);

    // Overrun: hold 0x3C while 0xC3 arrives
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h3C});
    send_char(1'b0, 8'h3C, 1'b0);
    send_char(1'b0, 8'hC3, 1'b0);
    wait_cycles(6);
    check("held_valid", rx_valid, 1);
    check("held_data", rx_data, 8'h3C);
    check("ovr_pulse", ovr_cnt, 1);
    check("link_up_after_ovr", link_up, 1);
    rx_ready = 1'b1;
    wait_cycles(3);
    check("valid_dropped", rx_valid, 0);
    check("queue_drained_2", exp_q.size(), 0);

    // Disconnect timeout after the line goes quiet
    clear_counts();
    send_null();
    cyc = 0;
    for (int i = 0; i < 200 && disc_cnt == 0; i++) begin
      wait_cycles(1);
      cyc++;
    end
    check("disc_seen", disc_cnt, 1);
    check("disc_timing", 32'(cyc >= 62 && cyc <= 66), 32'd1);
    check("link_down_disc", link_up, 0);

    // Asynchronous reset mid-character with a character held
    send_null();
    rx_ready = 1'b0;
    send_char(1'b0, 8'h5A, 1'b0);
    wait_cycles(6);
    check("held_before_reset", {rx_valid, rx_data}, {1'b1, 8'h5A});
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #1 rst = 1'b1;
    #1;
    check("reset_async_outputs", {rx_data, rx_ctrl, rx_valid, fct_rcvd, null_rcvd, link_up,
                                  err_parity, err_esc, err_disc, err_ovr}, 32'd0);
    rx_ready = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(4);
    check("queue_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
